// File: rtl/data_mem_resp_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
//   master (MEM stage): drives req_valid/req_we/req_addr/req_wdata/req_funct3
//                       and rsp_ready; observes req_ready/rsp_valid/rsp_rdata/rsp_err
//   slave  (responder): the mirror image
interface data_mem_resp_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Single-cycle RV32I data memory with a one-deep response register.
// Holds 2^(ADDR_W-2) 32-bit words, little-endian byte lanes.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; clears state and every memory word
//   bus  - data_mem_resp_if.slave: req_* request handshake in, rsp_* response out
// A request is accepted when req_valid && req_ready; stores write at the
// accepting edge, loads read at that edge, and the response appears the
// following cycle and is held until rsp_ready.
module data_mem_resp #(
  parameter int unsigned ADDR_W = 8
) (
  input logic            clk,
  input logic            rst,
  data_mem_resp_if.slave bus
);

  localparam int unsigned DEPTH = 1 << (ADDR_W - 2);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] widx;
  logic [1:0]        lane;
  logic [31:0]       word;
  logic [31:0]       shifted;
  logic [31:0]       wdata_sh;
  logic [31:0]       rdata_d;
  logic              err_d;
  logic [3:0]        be_d;

  // Ready depends only on the response slot: free, or being drained this cycle.
  assign bus.req_ready = (state_q == IDLE) || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign widx     = bus.req_addr[ADDR_W-1:2];
  assign lane     = bus.req_addr[1:0];
  assign word     = mem_q[widx];
  assign shifted  = word >> {lane, 3'b000};
  assign wdata_sh = bus.req_wdata << {lane, 3'b000};

  // Size/sign decode, alignment and legality checks, load extraction and
  // store byte enables. Errors and stores always report zero data.
  always_comb begin
    err_d   = 1'b0;
    rdata_d = '0;
    be_d    = '0;
    unique case (bus.req_funct3)
      3'b000: begin
        be_d    = 4'b0001 << lane;
        rdata_d = {{24{shifted[7]}}, shifted[7:0]};
      end
      3'b001: begin
        if (lane[0]) begin
          err_d = 1'b1;
        end else begin
          be_d    = 4'b0011 << lane;
          rdata_d = {{16{shifted[15]}}, shifted[15:0]};
        end
      end
      3'b010: begin
        if (lane != 2'b00) begin
          err_d = 1'b1;
        end else begin
          be_d    = 4'b1111;
          rdata_d = shifted;
        end
      end
      3'b100: begin
        if (bus.req_we) begin
          err_d = 1'b1;
        end else begin
          rdata_d = {24'b0, shifted[7:0]};
        end
      end
      3'b101: begin
        if (bus.req_we || lane[0]) begin
          err_d = 1'b1;
        end else begin
          rdata_d = {16'b0, shifted[15:0]};
        end
      end
      default: err_d = 1'b1;
    endcase
    if (bus.req_we || err_d) begin
      rdata_d = '0;
    end
    if (!bus.req_we || err_d) begin
      be_d = '0;
    end
  end

  // Storage: written on the accepting edge so a load accepted next cycle sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_d[b]) begin
          mem_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Response FSM with registered outputs. Acceptance in RESP replaces the
  // held response in the same edge that the old one is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RESP;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end
        end
        RESP: begin
          if (accept) begin
            state_q <= RESP;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end else if (bus.rsp_ready) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
